sweep_scheduler: RTL and testbench
==================================

Name: sweep_scheduler

Overview:
- Frequency-sweep sequencer for the VNA DDS path.
- Emits one frequency (phase-increment) word per sweep point over AXI-Stream, into the downstream AXIS-to-register latch that drives the DDS.
- After each word is accepted: a settle interval, then a dwell interval with acquisition enabled.
- Steps through cfg_npoints points: word = cfg_start + k*cfg_step.

Parameters:
- FREQ_WIDTH, 32, width of frequency word and AXIS tdata.
- CNT_WIDTH, 32, width of settle/dwell counters.
- PTS_WIDTH, 16, width of point count/index.

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  synchronous active-low reset, sampled on aclk.
- cfg_start  in  FREQ_WIDTH  first frequency word.
- cfg_step  in  FREQ_WIDTH  per-point increment (two's complement allowed).
- cfg_npoints  in  PTS_WIDTH  number of points.
- cfg_settle  in  CNT_WIDTH  settle cycles after each word handshake.
- cfg_dwell  in  CNT_WIDTH  acquisition cycles per point.
- start  in  1  level/pulse; begins sweep when sampled high in IDLE.
- abort  in  1  terminates sweep.
- m_axis_tdata  out  FREQ_WIDTH  frequency word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- acq_en  out  1  high during DWELL.
- point_idx  out  PTS_WIDTH  index of current point.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (aresetn low at edge): state IDLE; all outputs 0 (tdata, tvalid, acq_en, point_idx, busy, done); counters cleared.
- Config is sampled into internal registers on the start cycle. Changes mid-sweep have no effect.
- States: IDLE, LOAD, SETTLE, DWELL, DONE.
- IDLE:
  - start=1 and cfg_npoints>0 -> LOAD next cycle. busy=1, point_idx=0, tdata=cfg_start, tvalid=1.
  - start=1 and cfg_npoints=0 -> DONE. No transfer.
- LOAD:
  - tvalid held high and tdata held stable until tvalid&tready.
  - On handshake: tvalid=0 next cycle.
  - Next state is SETTLE if settle>0, else DWELL.
- SETTLE: lasts exactly cfg_settle cycles, then DWELL.
- DWELL:
  - acq_en=1 for exactly max(cfg_dwell,1) cycles.
  - After the last dwell cycle: if point_idx==npoints-1 -> DONE; else -> LOAD with point_idx+1 and tdata+=step.
- Frequency arithmetic is modulo 2^FREQ_WIDTH. Wrap-around is silent.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. done and busy are never high together.
- start while busy is ignored.
- start held high continuously: a new sweep begins the cycle after DONE returns to IDLE.
- abort=1 in any non-IDLE state -> IDLE next cycle.
  - tvalid, acq_en and busy drop to 0.
  - No done pulse.
  - point_idx holds its last value.
  - abort has priority over handshake and counter expiry in the same cycle.
  - This deliberately violates the AXIS no-retract rule; the downstream latch tolerates it.
- abort in IDLE has no effect. Simultaneous start+abort in IDLE: abort wins, stays IDLE.
- Latency: start edge to first tvalid = 1 cycle. Handshake to first acq_en = cfg_settle+1 cycles.

Optional Feature:
- Macro SWEEP_SCHEDULER_LOOP_EN.
- When defined: adds input port cfg_loop (1 bit), sampled at start. If set, the last point's DWELL goes to LOAD with point_idx=0 and tdata=cfg_start instead of DONE. The sweep repeats until abort, and done never pulses.
- When undefined: no cfg_loop port; behaviour as above.

Test Plan:
- start=0x1000, step=0x100, npoints=3, settle=2, dwell=4, tready=1:
  - tdata sequence 0x1000, 0x1100, 0x1200.
  - acq_en 4 cycles per point, each preceded by 3 cycles from handshake.
  - done single pulse; busy low after.
- Same config, tready low for 5 cycles on point 1: tdata=0x1100 and tvalid held stable for all 5 cycles; settle starts only after handshake.
- npoints=0: done pulses 2 cycles after start; no tvalid; busy never high.
- start=0xFFFFFF00, step=0x100, npoints=2: second word 0x00000000 (wrap).
- abort asserted during DWELL of point 1 of 3: next cycle busy=0, acq_en=0, no done, point_idx=1. A new start then restarts from cfg_start.
- aresetn low mid-SETTLE: all outputs 0 after the edge. With SWEEP_SCHEDULER_LOOP_EN and cfg_loop=1, npoints=2: tdata sequence start, start+step, start, ... and no done pulse.

Source files
------------

// File: rtl/sweep_scheduler.sv
// sweep_scheduler: frequency-sweep sequencer for the VNA DDS path.
// For each sweep point k it sends one AXI-Stream word cfg_start + k*cfg_step
// to the DDS register latch, waits cfg_settle cycles after the handshake, then
// holds acq_en high for max(cfg_dwell,1) cycles. Configuration is captured on
// the accepted start cycle; later changes to the cfg_* inputs are ignored.
//
// Optional build macro SWEEP_SCHEDULER_LOOP_EN adds cfg_loop: when set at
// start, the sweep restarts from cfg_start after the last point and runs
// until abort, with no done pulse.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   cfg_start/step       first frequency word / per-point increment
//   cfg_npoints          number of sweep points (0 -> immediate done)
//   cfg_settle/dwell     settle cycles after handshake / acquisition cycles
//   start, abort         begin sweep (in IDLE) / terminate sweep at once
//   cfg_loop             (SWEEP_SCHEDULER_LOOP_EN only) continuous sweep
//   m_axis_*             frequency word stream to the DDS latch
//   acq_en               high during the dwell interval
//   point_idx            index of the current point
//   busy, done           sweep in progress / one-cycle completion pulse
module sweep_scheduler #(
  parameter int unsigned FREQ_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned PTS_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [FREQ_WIDTH-1:0] cfg_start,
  input  logic [FREQ_WIDTH-1:0] cfg_step,
  input  logic [PTS_WIDTH-1:0]  cfg_npoints,
  input  logic [CNT_WIDTH-1:0]  cfg_settle,
  input  logic [CNT_WIDTH-1:0]  cfg_dwell,
  input  logic                  start,
  input  logic                  abort,
`ifdef SWEEP_SCHEDULER_LOOP_EN
  input  logic                  cfg_loop,
`endif
  output logic [FREQ_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  acq_en,
  output logic [PTS_WIDTH-1:0]  point_idx,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]            state_q,  state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [FREQ_WIDTH-1:0] tdata_q,  tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  acq_q,    acq_d;
  logic [PTS_WIDTH-1:0]  idx_q,    idx_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  // Configuration captured at start
  logic [FREQ_WIDTH-1:0] base_q,   base_d;
  logic [FREQ_WIDTH-1:0] step_q,   step_d;
  logic [PTS_WIDTH-1:0]  npts_q,   npts_d;
  logic [CNT_WIDTH-1:0]  settle_q, settle_d;
  logic [CNT_WIDTH-1:0]  dwell_q,  dwell_d;
`ifdef SWEEP_SCHEDULER_LOOP_EN
  logic                  loop_q,   loop_d;
`endif

  // Counter reload values: the counter counts down to zero inclusive, and a
  // zero dwell still yields one acquisition cycle.
  logic [CNT_WIDTH-1:0] settle_last_c;
  logic [CNT_WIDTH-1:0] dwell_last_c;
  logic                 handshake_c;
  logic                 last_point_c;

  assign settle_last_c = settle_q - CNT_WIDTH'(1);
  assign dwell_last_c  = (dwell_q == '0) ? '0 : dwell_q - CNT_WIDTH'(1);
  assign handshake_c   = tvalid_q & m_axis_tready;
  assign last_point_c  = (idx_q == npts_q - PTS_WIDTH'(1));

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    base_d   = base_q;
    step_d   = step_q;
    npts_d   = npts_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
`ifdef SWEEP_SCHEDULER_LOOP_EN
    loop_d   = loop_q;
`endif

    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          base_d   = cfg_start;
          step_d   = cfg_step;
          npts_d   = cfg_npoints;
          settle_d = cfg_settle;
          dwell_d  = cfg_dwell;
`ifdef SWEEP_SCHEDULER_LOOP_EN
          loop_d   = cfg_loop;
`endif
          cnt_d    = '0;
          if (cfg_npoints != '0) begin
            idx_d   = '0;
            tdata_d = cfg_start;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (handshake_c) begin
          if (settle_q != '0) begin
            cnt_d   = settle_last_c;
            state_d = S_SETTLE;
          end else begin
            cnt_d   = dwell_last_c;
            state_d = S_DWELL;
          end
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          cnt_d   = dwell_last_c;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          if (!last_point_c) begin
            idx_d   = idx_q + PTS_WIDTH'(1);
            tdata_d = tdata_q + step_q;
            state_d = S_LOAD;
          end else begin
`ifdef SWEEP_SCHEDULER_LOOP_EN
            if (loop_q) begin
              idx_d   = '0;
              tdata_d = base_q;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        // done is registered out of this state; abort here suppresses it
        state_d = S_IDLE;
        done_d  = !abort;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    tvalid_d = (state_d == S_LOAD);
    acq_d    = (state_d == S_DWELL);
    busy_d   = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_DWELL);
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      acq_q    <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      base_q   <= '0;
      step_q   <= '0;
      npts_q   <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
`ifdef SWEEP_SCHEDULER_LOOP_EN
      loop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      acq_q    <= acq_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      base_q   <= base_d;
      step_q   <= step_d;
      npts_q   <= npts_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
`ifdef SWEEP_SCHEDULER_LOOP_EN
      loop_q   <= loop_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign acq_en        = acq_q;
  assign point_idx     = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// Self-checking bench for sweep_scheduler. Expected frequency words are pushed
// to a scoreboard queue when a sweep is launched and popped on each handshake.
module tb_sweep_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_start, cfg_step;
  logic [15:0] cfg_npoints;
  logic [31:0] cfg_settle, cfg_dwell;
  logic        start, abort;
`ifdef SWEEP_SCHEDULER_LOOP_EN
  logic        cfg_loop;
`endif
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic        acq_en, busy, done;
  logic [15:0] point_idx;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 aclk = ~aclk;

  sweep_scheduler dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_npoints(cfg_npoints),
    .cfg_settle(cfg_settle), .cfg_dwell(cfg_dwell),
    .start(start), .abort(abort),
`ifdef SWEEP_SCHEDULER_LOOP_EN
    .cfg_loop(cfg_loop),
`endif
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .acq_en(acq_en), .point_idx(point_idx), .busy(busy), .done(done)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st,
                         input logic [15:0] n, input logic [31:0] se,
                         input logic [31:0] dw);
    cfg_start = s; cfg_step = st; cfg_npoints = n; cfg_settle = se; cfg_dwell = dw;
  endtask

  task automatic push_words(input logic [31:0] s, input logic [31:0] st, input int n);
    logic [31:0] w;
    w = s;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(w);
      w = w + st;
    end
  endtask

  // Run one sweep launched by a start pulse already driven by the caller.
  // Checks every handshake word, settle latency, dwell length and the done pulse.
  task automatic observe(input int settle, input int dwell, input int stall_pt,
                         input int stall_n, input bit expect_load,
                         output int done_cyc, output bit saw_busy, output bit saw_valid);
    int hs_cyc, run, pt, stall_left, dw_eff;
    bit prev_acq, finished;
    logic [31:0] w;
    hs_cyc = 0; run = 0; pt = 0; stall_left = stall_n; prev_acq = 1'b0;
    finished = 1'b0; done_cyc = -1; saw_busy = 1'b0; saw_valid = 1'b0;
    dw_eff = (dwell == 0) ? 1 : dwell;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      step();
      if (cyc == 0) begin
        start = 1'b0;
        // Scramble live config: the running sweep must ignore it
        cfg_start = ~cfg_start; cfg_step = cfg_step + 32'd7;
        cfg_npoints = cfg_npoints + 16'd5; cfg_settle = cfg_settle + 32'd1;
        n_checks++;
        if (m_axis_tvalid !== expect_load) begin
          n_fail++;
          $display("FAIL first_tvalid: got %b want %b", m_axis_tvalid, expect_load);
        end
      end
      if (cyc == 2 && busy) start = 1'b1;
      if (cyc == 3) start = 1'b0;
      if (busy) saw_busy = 1'b1;
      if (m_axis_tvalid) saw_valid = 1'b1;
      n_checks++;
      if (done && busy) begin
        n_fail++;
        $display("FAIL done_busy_overlap: cycle %0d", cyc);
      end
      m_axis_tready = 1'b1;
      if (m_axis_tvalid && pt == stall_pt && stall_left > 0) begin
        m_axis_tready = 1'b0;
        stall_left--;
        n_checks++;
        if (exp_q.size() == 0 || m_axis_tdata !== exp_q[0] || acq_en !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold: tdata %h acq %b cycle %0d", m_axis_tdata, acq_en, cyc);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word: got %h", m_axis_tdata);
        end else begin
          w = exp_q.pop_front();
          if (m_axis_tdata !== w || point_idx !== 16'(pt)) begin
            n_fail++;
            $display("FAIL word: got %h idx %0d want %h idx %0d", m_axis_tdata, point_idx, w, pt);
          end
        end
        hs_cyc = cyc;
        pt++;
      end
      if (acq_en && !prev_acq) begin
        n_checks++;
        if (cyc - hs_cyc !== settle + 1) begin
          n_fail++;
          $display("FAIL settle_latency: got %0d want %0d", cyc - hs_cyc, settle + 1);
        end
      end
      if (acq_en) run++;
      if (!acq_en && prev_acq) begin
        n_checks++;
        if (run !== dw_eff) begin
          n_fail++;
          $display("FAIL dwell_len: got %0d want %0d", run, dw_eff);
        end
        run = 0;
      end
      prev_acq = acq_en;
      if (done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
    end
    n_checks++;
    if (!finished || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_end: finished %b words left %0d", finished, exp_q.size());
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_done: done %b busy %b tvalid %b", done, busy, m_axis_tvalid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; m_axis_tready = 1'b1;
`ifdef SWEEP_SCHEDULER_LOOP_EN
    cfg_loop = 1'b0;
`endif
    set_cfg(32'h0, 32'h0, 16'd0, 32'd0, 32'd0);
    step(); step();
    n_checks++;
    if ({m_axis_tdata, m_axis_tvalid, acq_en, point_idx, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tdata %h tvalid %b acq %b idx %0d busy %b done %b",
               m_axis_tdata, m_axis_tvalid, acq_en, point_idx, busy, done);
    end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int dc; bit sb, sv;
    set_cfg(32'h1000, 32'h100, 16'd3, 32'd2, 32'd4);
    push_words(32'h1000, 32'h100, 3);
    start = 1'b1;
    observe(2, 4, -1, 0, 1'b1, dc, sb, sv);
  endtask

  task automatic test_stall();
    int dc; bit sb, sv;
    set_cfg(32'h1000, 32'h100, 16'd3, 32'd2, 32'd4);
    push_words(32'h1000, 32'h100, 3);
    start = 1'b1;
    observe(2, 4, 1, 5, 1'b1, dc, sb, sv);
  endtask

  task automatic test_zero_points();
    int dc; bit sb, sv;
    set_cfg(32'h55, 32'h1, 16'd0, 32'd2, 32'd4);
    start = 1'b1;
    observe(2, 4, -1, 0, 1'b0, dc, sb, sv);
    n_checks++;
    if (dc !== 1 || sb !== 1'b0 || sv !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_points: done_cyc %0d busy_seen %b tvalid_seen %b want 1 0 0", dc, sb, sv);
    end
  endtask

  task automatic test_zero_timing();
    int dc; bit sb, sv;
    set_cfg(32'hA0, 32'hFFFF_FFF0, 16'd3, 32'd0, 32'd0);
    push_words(32'hA0, 32'hFFFF_FFF0, 3);
    start = 1'b1;
    observe(0, 0, -1, 0, 1'b1, dc, sb, sv);
  endtask

  task automatic test_wrap();
    int dc; bit sb, sv;
    set_cfg(32'hFFFF_FF00, 32'h100, 16'd2, 32'd1, 32'd2);
    exp_q.push_back(32'hFFFF_FF00);
    exp_q.push_back(32'h0000_0000);
    start = 1'b1;
    observe(1, 2, -1, 0, 1'b1, dc, sb, sv);
  endtask

  task automatic test_abort();
    int dc; bit sb, sv, found, saw_done;
    set_cfg(32'h1000, 32'h100, 16'd3, 32'd2, 32'd4);
    start = 1'b1; m_axis_tready = 1'b1; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      start = 1'b0;
      if (acq_en && point_idx == 16'd1) found = 1'b1;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (!found || busy !== 1'b0 || acq_en !== 1'b0 || done !== 1'b0 ||
        m_axis_tvalid !== 1'b0 || point_idx !== 16'd1) begin
      n_fail++;
      $display("FAIL abort_dwell: found %b busy %b acq %b done %b tvalid %b idx %0d",
               found, busy, acq_en, done, m_axis_tvalid, point_idx);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: done/busy seen after abort");
    end
    set_cfg(32'h1000, 32'h100, 16'd3, 32'd2, 32'd4);
    push_words(32'h1000, 32'h100, 3);
    start = 1'b1;
    observe(2, 4, -1, 0, 1'b1, dc, sb, sv);
  endtask

  task automatic test_reset_mid_settle();
    bit found;
    set_cfg(32'h2000, 32'h10, 16'd2, 32'd6, 32'd2);
    start = 1'b1; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      start = 1'b0;
      if (busy && !m_axis_tvalid && !acq_en) found = 1'b1;
    end
    step();
    aresetn = 1'b0;
    step();
    n_checks++;
    if (!found || {m_axis_tdata, m_axis_tvalid, acq_en, point_idx, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_settle: found %b tdata %h tvalid %b acq %b idx %0d busy %b done %b",
               found, m_axis_tdata, m_axis_tvalid, acq_en, point_idx, busy, done);
    end
    aresetn = 1'b1;
    step(); step();
    n_checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: busy %b tvalid %b", busy, m_axis_tvalid);
    end
  endtask

  task automatic test_idle_abort();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start_abort: busy %b tvalid %b done %b", busy, m_axis_tvalid, done);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    set_cfg(32'h3000, 32'h1, 16'd1, 32'd0, 32'd1);
    start = 1'b1; m_axis_tready = 1'b1; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (done) found = 1'b1;
    end
    step();
    n_checks++;
    if (!found || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h3000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: done_seen %b tvalid %b tdata %h busy %b want 1 1 3000 1",
               found, m_axis_tvalid, m_axis_tdata, busy);
    end
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    step(); step();
  endtask

`ifdef SWEEP_SCHEDULER_LOOP_EN
  task automatic test_loop();
    bit saw_done;
    logic [31:0] w;
    set_cfg(32'h4000, 32'h40, 16'd2, 32'd1, 32'd1);
    push_words(32'h4000, 32'h40, 2);
    push_words(32'h4000, 32'h40, 2);
    cfg_loop = 1'b1; start = 1'b1; m_axis_tready = 1'b1; saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      start = 1'b0; cfg_loop = 1'b0;
      if (done) saw_done = 1'b1;
      if (m_axis_tvalid && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        n_checks++;
        if (m_axis_tdata !== w) begin
          n_fail++;
          $display("FAIL loop_word: got %h want %h", m_axis_tdata, w);
        end
      end
    end
    n_checks++;
    if (saw_done || exp_q.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL loop_run: done_seen %b words left %0d busy %b", saw_done, exp_q.size(), busy);
    end
    exp_q.delete();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_points();
    test_zero_timing();
    test_wrap();
    test_abort();
    test_reset_mid_settle();
    test_idle_abort();
    test_back_to_back();
`ifdef SWEEP_SCHEDULER_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
